bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Initiator side of the single-bit register bus.
- Accepts "move src -> dst" commands and drives the per-register out_use and in_use strobes that REG-style bus registers respond to.
- Commands are queued in a small FIFO and executed as SETUP/LATCH micro-sequences, so the bus is never driven by two sources at once.
- Sits between the instruction decoder and the register file.

Parameters:
- NREG, 4: number of bus registers; width of the strobe vectors.
- IDXW, 2: register index width; must satisfy 2**IDXW >= NREG.
- DEPTH, 4: command FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets all state.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command; equals !full.
- cmd_src  in  IDXW  source register index.
- cmd_dst  in  IDXW  destination register index.
- out_use  out  NREG  one-hot or zero; drives the source register onto the bus.
- in_use  out  NREG  one-hot or zero; destination captures the bus.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- done  out  1  one-cycle pulse per completed or dropped command.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FIFO emptied; FSM goes to IDLE.
  - out_use=0, in_use=0, done=0, busy=0, cmd_ready=1.
  - Applies mid-transfer: strobes drop on the next edge and the in-flight command is discarded without a done pulse.
- Push: cmd_valid && cmd_ready at an edge writes {src,dst} to the FIFO tail.
- All outputs are registered; no combinational path from cmd_* to any output.
- FSM states: IDLE, SETUP, LATCH, plus HOLD when the optional feature is enabled.
- IDLE:
  - FIFO non-empty: pop the head into a current-command register.
  - Valid command with src != dst: go to SETUP.
  - Otherwise: stay in IDLE and pulse done next cycle.
  - FIFO empty: stay in IDLE.
- SETUP: out_use[src]=1, in_use=0; next state is LATCH.
- LATCH:
  - out_use[src]=1 and in_use[dst]=1 for exactly one cycle.
  - done pulses in the following cycle.
  - FIFO non-empty: pop in LATCH and go directly to SETUP (or IDLE/no-op handling for a dropped command).
  - Otherwise: go to IDLE.
- Latency:
  - Command pushed at edge N into an empty, idle block: popped at N+1, SETUP during N+1..N+2, LATCH during N+2..N+3, done high during N+3..N+4.
  - Back-to-back throughput is 2 cycles per transfer.
- Dropped commands (no strobes, done still pulses once):
  - src == dst.
  - src or dst >= NREG.
- Bus safety: at most one out_use bit and one in_use bit are high in any cycle; in_use is never high without out_use.
- FIFO pointers:
  - Full/empty use IDXF+1-bit pointers with wrap-around.
  - Push while full is impossible because ready is low.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- busy deasserts in the cycle after the final LATCH (or final drop).

Optional Feature:
- Macro: XFER_HOLD_EN.
- Defined:
  - A HOLD state follows LATCH: out_use[src]=1, in_use=0 for one cycle.
  - The head pop and done move to the HOLD cycle.
  - Throughput becomes 3 cycles per transfer; latency to done becomes +1.
- Undefined: no HOLD state; timing as above.

Decomposition:
- Shared package xfer_pkg:
  - FSM state enum: IDLE, SETUP, LATCH, HOLD.
  - Default widths NREG, IDXW, DEPTH.
  - Packed command typedef {src,dst}.
- Sub-module xfer_fifo: synchronous FIFO with push/pop/full/empty/head, parameterised by DEPTH and entry width.
- The FSM and one-hot decode live in bus_xfer_ctrl.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with cmd_valid=1.
  - Required: out_use=0, in_use=0, done=0, busy=0, cmd_ready=1; nothing queued after release.
- Single move:
  - Stimulus: push src=1, dst=3 at edge N.
  - Required: out_use=4'b0010 during N+1..N+3; in_use=4'b1000 only during N+2..N+3; done pulses during N+3..N+4.
- Back-to-back:
  - Stimulus: push (0->2), (2->1), (3->0) on consecutive cycles.
  - Required: LATCH cycles 2 cycles apart; strobes 0001/0100, 0100/0010, 1000/0001; exactly 3 done pulses.
- Full FIFO:
  - Stimulus: push 5 commands while the FSM is busy.
  - Required: cmd_ready=0 after DEPTH entries; 5th held until ready; all 5 execute in order.
- Drops:
  - Stimulus: push src=dst=2, then src=1, dst=1.
  - Required: no strobe bits high; 2 done pulses.
- Mid-operation reset:
  - Stimulus: assert reset=0 during a LATCH cycle.
  - Required: strobes 0 on the next edge; no done pulse; FIFO empty.
- XFER_HOLD_EN build: repeat the single-move test; out_use stays high one extra cycle and done is delayed by 1.

Source files
------------

// File: rtl/xfer_pkg.sv
// Shared types and default sizing for the single-bit register bus transfer controller.
package xfer_pkg;

  localparam int NREG_DEF  = 4;
  localparam int IDXW_DEF  = 2;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } xfer_state_t;

  // Command layout at the default index width; src occupies the upper bits.
  typedef struct packed {
    logic [IDXW_DEF-1:0] src;
    logic [IDXW_DEF-1:0] dst;
  } xfer_cmd_t;

endpackage

// File: rtl/xfer_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers for full/empty and an occupancy count.
module xfer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int IDXF = $clog2(DEPTH);
  localparam logic [IDXF:0] PTR_ONE = (IDXF+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [IDXF:0] wp;
  logic [IDXF:0] rp;

  assign empty = (wp == rp);
  assign full  = (wp[IDXF] != rp[IDXF]) && (wp[IDXF-1:0] == rp[IDXF-1:0]);
  assign head  = mem[rp[IDXF-1:0]];
  assign level = wp - rp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[IDXF-1:0]] <= wdata;
        wp                <= wp + PTR_ONE;
      end
      if (pop && !empty) begin
        rp <= rp + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus initiator: queues "src -> dst" moves and sequences out_use/in_use strobes.
// Define XFER_HOLD_EN to add a HOLD cycle after LATCH (3-cycle throughput).
module bus_xfer_ctrl
  import xfer_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int IDXW  = IDXW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IDXW-1:0] cmd_src,
  input  logic [IDXW-1:0] cmd_dst,
  output logic [NREG-1:0] out_use,
  output logic [NREG-1:0] in_use,
  output logic            busy,
  output logic            done
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IDXW-1:0] src;
    logic [IDXW-1:0] dst;
  } cmd_t;

  xfer_state_t     state_q, state_nxt;
  cmd_t            cur_q, cur_nxt, head_cmd;
  logic            fifo_full, fifo_empty;
  logic [LW-1:0]   level, level_nxt;
  logic            push, pop;
  logic            adv, fin, head_ok;
  logic            done_nxt, busy_nxt;
  logic [NREG-1:0] out_nxt, in_nxt;

  function automatic logic cmd_ok(input cmd_t c);
    return (c.src != c.dst) && (int'(c.src) < NREG) && (int'(c.dst) < NREG);
  endfunction

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign head_ok   = cmd_ok(head_cmd);

  xfer_fifo #(
    .DEPTH (DEPTH),
    .W     (2*IDXW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({cmd_src, cmd_dst}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_cmd),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      out_use <= '0;
      in_use  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cur_q   <= cur_nxt;
      out_use <= out_nxt;
      in_use  <= in_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cur_nxt   = cur_q;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    case (state_q)
      IDLE:  adv = 1'b1;
      SETUP: state_nxt = LATCH;
      LATCH: begin
`ifdef XFER_HOLD_EN
        state_nxt = HOLD;
`else
        adv = 1'b1;
        fin = 1'b1;
`endif
      end
      HOLD: begin
        adv = 1'b1;
        fin = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // A drop found while finishing a transfer is left queued for IDLE so
    // that the two done pulses land in separate cycles.
    if (adv) begin
      state_nxt = IDLE;
      done_nxt  = fin;
      if (!fifo_empty && (head_ok || !fin)) begin
        pop     = 1'b1;
        cur_nxt = head_cmd;
        if (head_ok) state_nxt = SETUP;
        else         done_nxt  = 1'b1;
      end
    end
  end

  always_comb begin
    out_nxt   = '0;
    in_nxt    = '0;
    level_nxt = level + LW'(push) - LW'(pop);
    busy_nxt  = (state_nxt != IDLE) || (level_nxt != '0);
    for (int unsigned i = 0; i < NREG; i++) begin
      out_nxt[i] = (state_nxt != IDLE) && (cur_nxt.src == IDXW'(i));
      in_nxt[i]  = (state_nxt == LATCH) && (cur_nxt.dst == IDXW'(i));
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed self-checking bench for bus_xfer_ctrl; honours XFER_HOLD_EN if defined.
module tb_bus_xfer_ctrl;

`ifdef XFER_HOLD_EN
  localparam int TPUT = 3;
`else
  localparam int TPUT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [3:0] out_use;
  logic [3:0] in_use;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int done_cnt = 0;
  int strobe_cyc = 0;
  int viol = 0;
  logic [3:0] lat_out [$];
  logic [3:0] lat_in  [$];
  int         lat_cyc [$];

  always #5 clk = ~clk;

  bus_xfer_ctrl #(
    .NREG  (4),
    .IDXW  (2),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .out_use   (out_use),
    .in_use    (in_use),
    .busy      (busy),
    .done      (done)
  );

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (out_use !== 4'b0 || in_use !== 4'b0) strobe_cyc++;
    if ($countones(out_use) > 1 || $countones(in_use) > 1 ||
        (in_use != 4'b0 && out_use == 4'b0)) viol++;
    if (in_use != 4'b0) begin
      lat_out.push_back(out_use);
      lat_in.push_back(in_use);
      lat_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [1:0] d, output int waited);
    cmd_src   = s;
    cmd_dst   = d;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 50) begin
      tick;
      waited++;
    end
    if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) tick;
  endtask

  logic [1:0] fs [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] fd [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    int w, wsum, bl, bd, bs;

    // Reset with a command offered: nothing may be queued
    reset = 1'b0; cmd_valid = 1'b1; cmd_src = 2'd1; cmd_dst = 2'd2;
    tick; tick;
    check("rst_out_use", 32'(out_use), 32'h0);
    check("rst_in_use",  32'(in_use),  32'h0);
    check("rst_done",    32'(done),    32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_ready",   32'(cmd_ready), 32'h1);
    cmd_valid = 1'b0; reset = 1'b1;
    bd = done_cnt; bs = strobe_cyc;
    repeat (4) tick;
    check("rst_busy_after", 32'(busy), 32'h0);
    check("rst_no_done",    32'(done_cnt - bd), 32'd0);
    check("rst_no_strobe",  32'(strobe_cyc - bs), 32'd0);

    // Single move 1 -> 3, cycle-exact
    cmd_src = 2'd1; cmd_dst = 2'd3; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check("sm_n0_out",  32'(out_use), 32'h0);
    check("sm_n0_busy", 32'(busy), 32'h1);
    tick;
    check("sm_setup_out", 32'(out_use), 32'h2);
    check("sm_setup_in",  32'(in_use),  32'h0);
    tick;
    check("sm_latch_out",  32'(out_use), 32'h2);
    check("sm_latch_in",   32'(in_use),  32'h8);
    check("sm_latch_done", 32'(done),    32'h0);
`ifdef XFER_HOLD_EN
    tick;
    check("sm_hold_out",  32'(out_use), 32'h2);
    check("sm_hold_in",   32'(in_use),  32'h0);
    check("sm_hold_done", 32'(done),    32'h0);
`endif
    tick;
    check("sm_fin_out",  32'(out_use), 32'h0);
    check("sm_fin_in",   32'(in_use),  32'h0);
    check("sm_fin_done", 32'(done),    32'h1);
    check("sm_fin_busy", 32'(busy),    32'h0);
    tick;
    check("sm_done_once", 32'(done), 32'h0);

    // Back-to-back moves
    bl = lat_out.size(); bd = done_cnt;
    push(2'd0, 2'd2, w);
    push(2'd2, 2'd1, w);
    push(2'd3, 2'd0, w);
    wait_idle;
    check("b2b_latches", 32'(lat_out.size() - bl), 32'd3);
    check("b2b_done",    32'(done_cnt - bd), 32'd3);
    if (lat_out.size() - bl == 3) begin
      check("b2b0_out", 32'(lat_out[bl]),   32'h1);
      check("b2b0_in",  32'(lat_in[bl]),    32'h4);
      check("b2b1_out", 32'(lat_out[bl+1]), 32'h4);
      check("b2b1_in",  32'(lat_in[bl+1]),  32'h2);
      check("b2b2_out", 32'(lat_out[bl+2]), 32'h8);
      check("b2b2_in",  32'(lat_in[bl+2]),  32'h1);
      check("b2b_gap01", 32'(lat_cyc[bl+1] - lat_cyc[bl]),   32'(TPUT));
      check("b2b_gap12", 32'(lat_cyc[bl+2] - lat_cyc[bl+1]), 32'(TPUT));
    end

    // Fill the FIFO: later pushes must stall on cmd_ready
    bl = lat_out.size(); bd = done_cnt; wsum = 0;
    for (int i = 0; i < 8; i++) begin
      push(fs[i], fd[i], w);
      wsum += w;
    end
    wait_idle;
    check("full_stalled", 32'(wsum > 0), 32'd1);
    check("full_latches", 32'(lat_out.size() - bl), 32'd8);
    check("full_done",    32'(done_cnt - bd), 32'd8);
    if (lat_out.size() - bl == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("full%0d_out", i), 32'(lat_out[bl+i]), 32'(4'b0001 << fs[i]));
        check($sformatf("full%0d_in", i),  32'(lat_in[bl+i]),  32'(4'b0001 << fd[i]));
      end
    end

    // Dropped commands: src == dst
    bd = done_cnt; bs = strobe_cyc;
    push(2'd2, 2'd2, w);
    push(2'd1, 2'd1, w);
    wait_idle;
    check("drop_done",      32'(done_cnt - bd), 32'd2);
    check("drop_no_strobe", 32'(strobe_cyc - bs), 32'd0);

    // Reset during LATCH with a second command still queued
    push(2'd0, 2'd1, w);
    push(2'd1, 2'd3, w);
    tick;
    check("mr_in_latch", 32'(in_use), 32'h2);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("mr_out",   32'(out_use), 32'h0);
    check("mr_in",    32'(in_use),  32'h0);
    check("mr_done",  32'(done),    32'h0);
    check("mr_busy",  32'(busy),    32'h0);
    check("mr_ready", 32'(cmd_ready), 32'h1);
    bd = done_cnt; bs = strobe_cyc;
    repeat (6) tick;
    check("mr_no_done",   32'(done_cnt - bd), 32'd0);
    check("mr_no_strobe", 32'(strobe_cyc - bs), 32'd0);
    check("mr_idle",      32'(busy), 32'h0);

    check("bus_safety", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
